// File: rtl/square_energy_gate_if.sv
// Bus between the squaring multiplier/cutter side and square_energy_gate:
// the squared sample stream and controls in, window energy and gate status out.
interface square_energy_gate_if #(
    parameter int OP_WIDTH   = 16,
    parameter int WINDOW_LEN = 64
);
    localparam int RES_WIDTH = 2 * OP_WIDTH;
    localparam int CNT_W     = $clog2(WINDOW_LEN);
    localparam int ACC_WIDTH = RES_WIDTH + CNT_W;

    logic                 sq_valid;
    logic [RES_WIDTH-1:0] sq_data;
    logic [ACC_WIDTH-1:0] threshold;
    logic                 clear;
    logic [ACC_WIDTH-1:0] energy;
    logic                 energy_valid;
    logic                 over_thresh;
    logic                 active;
    logic [CNT_W-1:0]     window_cnt;

    modport master (
        output sq_valid, sq_data, threshold, clear,
        input  energy, energy_valid, over_thresh, active, window_cnt
    );

    modport slave (
        input  sq_valid, sq_data, threshold, clear,
        output energy, energy_valid, over_thresh, active, window_cnt
    );
endinterface

// File: rtl/square_energy_gate.sv
// Non-overlapping window energy of squared samples, strict threshold compare,
// and an ON/OFF hysteresis gate driving the cutter's segment-active signal.
module square_energy_gate #(
    parameter int OP_WIDTH    = 16,
    parameter int WINDOW_LEN  = 64,
    parameter int ON_WINDOWS  = 2,
    parameter int OFF_WINDOWS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    square_energy_gate_if.slave   bus
);
    localparam int RES_WIDTH = 2 * OP_WIDTH;
    localparam int CNT_W     = $clog2(WINDOW_LEN);
    localparam int ACC_WIDTH = RES_WIDTH + CNT_W;
    localparam int RUN_MAX   = (ON_WINDOWS > OFF_WINDOWS) ? ON_WINDOWS : OFF_WINDOWS;
    localparam int RUN_W     = $clog2(RUN_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LEN - 1);
    localparam logic [RUN_W-1:0] ON_RUN   = RUN_W'(ON_WINDOWS);
    localparam logic [RUN_W-1:0] OFF_RUN  = RUN_W'(OFF_WINDOWS);

    typedef enum logic [1:0] {
        QUIET   = 2'd0,
        RISING  = 2'd1,
        ACTIVE  = 2'd2,
        FALLING = 2'd3
    } state_t;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     window_cnt_q, window_cnt_d;
    logic [ACC_WIDTH-1:0] energy_q, energy_d;
    logic                 energy_valid_q, energy_valid_d;
    logic                 over_thresh_q, over_thresh_d;
    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic                 active_q, active_d;

    logic [ACC_WIDTH-1:0] sum;
    logic [RUN_W-1:0]     run_inc;

    assign sum     = acc_q + ACC_WIDTH'(bus.sq_data);
    assign run_inc = run_q + RUN_W'(1);

    // Window accumulation; clear dominates a coincident close.
    always_comb begin
        acc_d          = acc_q;
        window_cnt_d   = window_cnt_q;
        energy_d       = energy_q;
        over_thresh_d  = over_thresh_q;
        energy_valid_d = 1'b0;
        if (bus.clear) begin
            acc_d        = '0;
            window_cnt_d = '0;
        end else if (bus.sq_valid) begin
            if (window_cnt_q == LAST_CNT) begin
                energy_d       = sum;
                over_thresh_d  = (sum > bus.threshold);
                energy_valid_d = 1'b1;
                acc_d          = '0;
                window_cnt_d   = '0;
            end else begin
                acc_d        = sum;
                window_cnt_d = window_cnt_q + CNT_W'(1);
            end
        end
    end

    // Hysteresis acts on the registered window result, so active lags energy_valid by one cycle.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        active_d = active_q;
        if (energy_valid_q) begin
            unique case (state_q)
                QUIET: begin
                    if (over_thresh_q) begin
                        if (ON_RUN == RUN_W'(1)) begin
                            state_d  = ACTIVE;
                            run_d    = '0;
                            active_d = 1'b1;
                        end else begin
                            state_d = RISING;
                            run_d   = RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                RISING: begin
                    if (over_thresh_q) begin
                        if (run_inc >= ON_RUN) begin
                            state_d  = ACTIVE;
                            run_d    = '0;
                            active_d = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = QUIET;
                        run_d   = '0;
                    end
                end
                ACTIVE: begin
                    if (!over_thresh_q) begin
                        if (OFF_RUN == RUN_W'(1)) begin
                            state_d  = QUIET;
                            run_d    = '0;
                            active_d = 1'b0;
                        end else begin
                            state_d = FALLING;
                            run_d   = RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                FALLING: begin
                    if (!over_thresh_q) begin
                        if (run_inc >= OFF_RUN) begin
                            state_d  = QUIET;
                            run_d    = '0;
                            active_d = 1'b0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = ACTIVE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d  = QUIET;
                    run_d    = '0;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_q          <= '0;
            window_cnt_q   <= '0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
            over_thresh_q  <= 1'b0;
            state_q        <= QUIET;
            run_q          <= '0;
            active_q       <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            window_cnt_q   <= window_cnt_d;
            energy_q       <= energy_d;
            energy_valid_q <= energy_valid_d;
            over_thresh_q  <= over_thresh_d;
            state_q        <= state_d;
            run_q          <= run_d;
            active_q       <= active_d;
        end
    end

    assign bus.energy       = energy_q;
    assign bus.energy_valid = energy_valid_q;
    assign bus.over_thresh  = over_thresh_q;
    assign bus.active       = active_q;
    assign bus.window_cnt   = window_cnt_q;

endmodule

// File: tb/tb_square_energy_gate.sv
// Directed bench for square_energy_gate (WINDOW_LEN=4): expected windows are queued
// at stimulus time and a negedge monitor checks every energy_valid pulse.
module tb_square_energy_gate;
    localparam int WL = 4;
    localparam int AW = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    square_energy_gate_if #(.OP_WIDTH(16), .WINDOW_LEN(WL)) bus_if ();

    square_energy_gate #(
        .OP_WIDTH(16), .WINDOW_LEN(WL), .ON_WINDOWS(2), .OFF_WINDOWS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if)
    );

    typedef struct {
        logic [AW-1:0] e;
        logic          o;
        int            c;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest queued window at its predicted cycle.
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].c < cyc) begin
            x = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_pulse: no energy_valid at cycle %0d, expected energy %0h", x.c, x.e);
        end
        if (bus_if.energy_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: energy_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                x = sb.pop_front();
                chk("energy", 64'(bus_if.energy), 64'(x.e));
                chk("over_thresh", 64'(bus_if.over_thresh), 64'(x.o));
                chk("pulse_cycle", 64'(cyc), 64'(x.c));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic c);
        bus_if.sq_valid = v;
        bus_if.sq_data  = d;
        bus_if.clear    = c;
        @(posedge clk);
        #1;
        bus_if.sq_valid = 1'b0;
        bus_if.clear    = 1'b0;
    endtask

    task automatic expect_win(input logic [AW-1:0] e);
        exp_t x;
        x.e = e;
        x.o = (e > bus_if.threshold);
        x.c = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic win(input logic [31:0] e);
        step(1'b1, e, 1'b0);
        step(1'b1, 32'd0, 1'b0);
        step(1'b1, 32'd0, 1'b0);
        expect_win(AW'(e));
        step(1'b1, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        bus_if.sq_valid  = 1'b0;
        bus_if.sq_data   = '0;
        bus_if.threshold = '0;
        bus_if.clear     = 1'b0;

        do_reset();
        chk("rst_energy", 64'(bus_if.energy), 64'd0);
        chk("rst_energy_valid", 64'(bus_if.energy_valid), 64'd0);
        chk("rst_over_thresh", 64'(bus_if.over_thresh), 64'd0);
        chk("rst_active", 64'(bus_if.active), 64'd0);
        chk("rst_window_cnt", 64'(bus_if.window_cnt), 64'd0);

        // Basic window, threshold 0
        for (int i = 0; i < 3; i++) step(1'b1, 32'h014B5A90, 1'b0);
        expect_win(34'h052D6A40);
        step(1'b1, 32'h014B5A90, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("cnt_after_close", 64'(bus_if.window_cnt), 64'd0);

        // Back-to-back full-scale windows
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) expect_win(34'h3FFF80004);
            step(1'b1, 32'hFFFE0001, 1'b0);
            chk("window_cnt_b2b", 64'(bus_if.window_cnt), 64'((i + 1) % 4));
        end
        step(1'b0, 32'd0, 1'b0);

        // Clear mid-window drops partial sum and the cleared sample
        step(1'b1, 32'd1, 1'b0);
        step(1'b1, 32'd1, 1'b0);
        step(1'b1, 32'd1, 1'b1);
        chk("cnt_after_clear", 64'(bus_if.window_cnt), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd1, 1'b0);
        expect_win(34'd4);
        step(1'b1, 32'd1, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // Clear coinciding with a close suppresses the pulse
        for (int i = 0; i < 3; i++) step(1'b1, 32'd1, 1'b0);
        step(1'b1, 32'd1, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        chk("cnt_clear_close", 64'(bus_if.window_cnt), 64'd0);
        chk("energy_kept_after_clear", 64'(bus_if.energy), 64'd4);

        // Hysteresis
        do_reset();
        bus_if.threshold = 34'd10;
        win(32'd20); step(1'b0, 32'd0, 1'b0);
        chk("active_after_one_above", 64'(bus_if.active), 64'd0);
        win(32'd20);
        chk("active_lags_pulse", 64'(bus_if.active), 64'd0);
        step(1'b0, 32'd0, 1'b0);
        chk("active_rise", 64'(bus_if.active), 64'd1);
        win(32'd10); step(1'b0, 32'd0, 1'b0);
        chk("active_hold_1", 64'(bus_if.active), 64'd1);
        win(32'd10); step(1'b0, 32'd0, 1'b0);
        chk("active_hold_2", 64'(bus_if.active), 64'd1);
        win(32'd10);
        chk("active_fall_lag", 64'(bus_if.active), 64'd1);
        step(1'b0, 32'd0, 1'b0);
        chk("active_fall", 64'(bus_if.active), 64'd0);
        win(32'd5);  step(1'b0, 32'd0, 1'b0);
        chk("active_quiet_a", 64'(bus_if.active), 64'd0);
        win(32'd20); step(1'b0, 32'd0, 1'b0);
        chk("active_quiet_b", 64'(bus_if.active), 64'd0);
        win(32'd5);  step(1'b0, 32'd0, 1'b0);
        chk("active_quiet_c", 64'(bus_if.active), 64'd0);

        // Reset in mid-window while active
        win(32'd20); step(1'b0, 32'd0, 1'b0);
        win(32'd20); step(1'b0, 32'd0, 1'b0);
        chk("active_before_rst", 64'(bus_if.active), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd1, 1'b0);
        chk("cnt_before_rst", 64'(bus_if.window_cnt), 64'd3);
        rst_n = 1'b1;
        step(1'b1, 32'd1, 1'b1);
        rst_n = 1'b0;
        chk("midrst_active", 64'(bus_if.active), 64'd0);
        chk("midrst_cnt", 64'(bus_if.window_cnt), 64'd0);
        chk("midrst_energy", 64'(bus_if.energy), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd1, 1'b0);
        expect_win(34'd4);
        step(1'b1, 32'd1, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // Gapped valid
        for (int i = 0; i < 7; i++) begin
            if (i == 6) expect_win(34'd28);
            step(pat[i] != 0, 32'd7, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/square_energy_gate.md
Name: square_energy_gate

Overview:
Sits directly downstream of the squaring multiplier in the ThresholdCutter path. It consumes one squared sample per valid cycle and sums WINDOW_LEN squares into a non-overlapping window energy. It compares each window energy with a runtime threshold. A hysteresis state machine turns those comparisons into a stable "segment active" gate for the cutter.

Parameters:
OP_WIDTH, 16, width of the raw sample fed to the squarer
RES_WIDTH, 2*OP_WIDTH (derived, not overridable), width of the squared input
WINDOW_LEN, 64, squares per window; must be a power of two and at least 2
ACC_WIDTH, RES_WIDTH + log2(WINDOW_LEN) (derived), accumulator and energy width
ON_WINDOWS, 2, consecutive above-threshold windows needed to raise active
OFF_WINDOWS, 3, consecutive at-or-below-threshold windows needed to drop active

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on clk
sq_valid  in  1  sq_data is valid this cycle
sq_data  in  RES_WIDTH  squared sample from the multiplier
threshold  in  ACC_WIDTH  window-energy threshold, sampled at the window close
clear  in  1  synchronous restart of the current partial window
energy  out  ACC_WIDTH  last completed window energy
energy_valid  out  1  one-cycle pulse: energy/over_thresh updated
over_thresh  out  1  last window energy > threshold (strict)
active  out  1  hysteresis gate output
window_cnt  out  log2(WINDOW_LEN)  samples accepted in the current window

Behaviour:
- Reset (rst_n=1 at a clk edge): acc=0, window_cnt=0, energy=0, energy_valid=0, over_thresh=0, active=0, run counter=0, FSM=QUIET. Reset overrides clear and sq_valid. Reset in mid-window discards the partial sum.
- Accumulate when sq_valid=1 and window_cnt<WINDOW_LEN-1: acc+=sq_data and window_cnt++.
- Window close when sq_valid=1 and window_cnt==WINDOW_LEN-1. On that same edge:
  - energy <= acc+sq_data
  - over_thresh <= (acc+sq_data) > threshold
  - energy_valid <= 1 for exactly one cycle
  - acc <= 0, window_cnt <= 0
- Latency: energy_valid goes high 1 cycle after the WINDOW_LEN-th accepted sample.
- Back-to-back windows: the close cycle accepts a sample and the next cycle may start the next window; no bubble and no sample loss.
- sq_valid=0: hold all state, energy_valid=0.
- Arithmetic: unsigned. ACC_WIDTH guarantees no overflow; all-ones input for a full window is exact.
- clear=1: acc<=0 and window_cnt<=0, and the sample in that cycle is dropped.
  - If clear and a window close coincide, clear wins: no energy_valid pulse.
  - clear does not touch energy, over_thresh, active or the FSM.
- Hysteresis FSM is evaluated only on the energy_valid cycle, using the new over_thresh. run counts consecutive qualifying windows.
  - QUIET (active=0): above → run=1; if ON_WINDOWS==1 go ACTIVE, else go RISING.
  - RISING (active=0): above → run++, go ACTIVE when run reaches ON_WINDOWS; not above → QUIET, run=0.
  - ACTIVE (active=1): not above → run=1; if OFF_WINDOWS==1 go QUIET, else go FALLING.
  - FALLING (active=1): not above → run++, go QUIET when run reaches OFF_WINDOWS; above → ACTIVE, run=0.
  - active is registered and changes on the edge after the deciding energy_valid pulse, so it lags energy_valid by 1 cycle.
- threshold may change at any time; only the value at a window close matters.

Test Plan:
- Bench uses WINDOW_LEN=4 (ACC_WIDTH=34).
- Reset, then 4 × sq_data=32'h014B5A90 with threshold=0 → 1 cycle after the 4th sample: energy=34'h052D6A40, energy_valid pulses once, over_thresh=1.
- 8 × 32'hFFFE0001 back-to-back → two pulses 4 cycles apart, each energy=34'h3FFF80004 with no wrap; window_cnt goes 0,1,2,3,0.
- 2 samples, then clear=1 together with a 3rd sample, then 4 × 32'h00000001 → a single pulse with energy=4.
- threshold=10, windows of energy 20,20 → active rises 1 cycle after the 2nd pulse. Then windows of 10,10,10 (equal is not above) → active falls 1 cycle after the 3rd pulse. A sequence of 5,20,5 → active stays 0.
- Drive rst_n=1 in mid-window, with active=1 and 3 samples held. Release and send 4 × 1 → active=0 immediately after reset; next energy=4.
- Gapped sq_valid (1,0,0,1,1,0,1) with sq_data=7 → one pulse, energy=28, 1 cycle after the 4th valid sample.
